gate_checker: RTL and testbench
===============================

# gate_checker

Self-test sequencer for a 2-input combinational gate (NAND, AND, OR, XOR, …). It drives the gate through all four input vectors, holds each for a configurable settle time, and samples the gate output into an observed truth table. It then compares that table against an expected table supplied at start and reports the result with a start/busy/done handshake. It sits in front of any 2-input gate and replaces hand-written per-gate testbench stimulus with a reusable hardware checker.

## Interface

- SETTLE_CYCLES, 2, number of cycles each input vector is held before sampling; legal range 1..255.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a check run; accepted only in IDLE.
- abort  input  1  cancel a run in progress; effective only in DRIVE.
- tt_exp  input  4  expected truth table; bit i is the expected output for {a,b} = i. Sampled on the start-accept edge.
- gate_a  output  1  gate input a; equals vector index bit 1.
- gate_b  output  1  gate input b; equals vector index bit 0.
- gate_y  input  1  gate output under test.
- busy  output  1  high while in DRIVE.
- done  output  1  one-cycle pulse when a run completes normally.
- pass  output  1  high when fail_mask == 0; valid from the done pulse until the next start accept.
- tt_obs  output  4  observed truth table; bit i is gate_y sampled for vector i.
- fail_mask  output  4  tt_obs XOR latched tt_exp.

## Operation

- States: IDLE, DRIVE, DONE.
- IDLE:
  - start=1 → DRIVE.
  - On the accept edge: latch tt_exp; clear tt_obs, fail_mask and pass to 0; set vector index to 0; set settle counter to 0.
- DRIVE:
  - gate_a/gate_b are driven from the registered vector index.
  - The settle counter counts 0..SETTLE_CYCLES-1.
  - When the counter reaches SETTLE_CYCLES-1, that edge captures gate_y into tt_obs[idx], resets the counter, and increments idx.
  - Capturing idx=3 → DONE.
  - abort=1 → IDLE. Partial tt_obs is cleared to 0, pass=0, and done does not pulse.
  - If abort and the final capture occur on the same edge, abort wins.
- DONE:
  - Lasts exactly one cycle with done=1, then → IDLE.
  - fail_mask and pass are registered on the DONE-entry edge, using the final tt_obs including bit 3.
- start is ignored in DRIVE and DONE; it is not queued.
- abort is ignored in IDLE and DONE.
- Results (tt_obs, fail_mask, pass) hold their values in IDLE until the next start accept.
- gate_a/gate_b return to 0 in IDLE and DONE.

## Timing

- Reset: state=IDLE; gate_a, gate_b, busy, done, pass all 0; tt_obs, fail_mask both 4'b0000; latched tt_exp 0.
- Reset asserted mid-run aborts immediately on that edge with the same values; no done pulse.
- All outputs are registered; there is no combinational path from gate_y to any output.
- Start accepted at edge T:
  - busy=1 and vector 0 is driven from T+1.
  - Vector i is driven during cycles T+1+i·N .. T+i·N+N, where N = SETTLE_CYCLES.
  - The capture for vector i happens at the edge ending cycle T+(i+1)·N.
  - done=1 during cycle T+1+4N; busy drops in that same cycle.
- Back-to-back runs: the earliest accept is in the cycle after done (T+2+4N).
- gate_y must settle within N cycles minus the clock-to-output delay of gate_a/gate_b.

## Test plan

- NAND gate attached, N=2, tt_exp=4'b0111, start at cycle 0 → gate_a/b step through 00, 01, 10, 11 for 2 cycles each. Required: done pulse at cycle 9, tt_obs=0111, fail_mask=0000, pass=1.
- NAND gate attached, tt_exp=4'b1000 (AND table) → tt_obs=0111, fail_mask=1111, pass=0, done=1 once.
- gate_y tied to 0, tt_exp=4'b0111 → tt_obs=0000, fail_mask=0111, pass=0. With gate_y tied to 1: tt_obs=1111, fail_mask=1000.
- Pulse start again at cycles 3 and 9 during a run (N=2) → no second run and busy timing unchanged. Then a start at cycle 10 is accepted and done pulses at cycle 19.
- Assert abort at cycle 4 (N=2) → from cycle 5: busy=0, done never pulses, tt_obs=0000, pass=0. A subsequent start runs normally.
- Assert rst for 1 cycle at cycle 5 of a run → from cycle 6 all outputs equal their reset values, state IDLE. N=1 run with NAND → done at cycle 5, pass=1.

Source files
------------

// File: rtl/gate_checker.sv
// Self-test sequencer for a 2-input combinational gate: steps through all four
// input vectors, samples the gate output per vector and compares against an expected table.
module gate_checker #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] tt_exp,
    output logic       gate_a,
    output logic       gate_b,
    input  logic       gate_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] tt_obs,
    output logic [3:0] fail_mask
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] tt_exp_q, tt_exp_d;
    logic [3:0] tt_obs_q, tt_obs_d;
    logic [3:0] fail_mask_q, fail_mask_d;
    logic       pass_q, pass_d;
    logic       gate_a_q, gate_a_d;
    logic       gate_b_q, gate_b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [3:0] capture_obs;
    logic [3:0] final_mask;

    // Next-state, result capture and registered-output computation.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        tt_exp_d    = tt_exp_q;
        tt_obs_d    = tt_obs_q;
        fail_mask_d = fail_mask_q;
        pass_d      = pass_q;

        capture_obs         = tt_obs_q;
        capture_obs[idx_q]  = gate_y;
        final_mask          = capture_obs ^ tt_exp_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_DRIVE;
                    tt_exp_d    = tt_exp;
                    tt_obs_d    = 4'b0000;
                    fail_mask_d = 4'b0000;
                    pass_d      = 1'b0;
                    idx_d       = 2'd0;
                    cnt_d       = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                // abort takes priority over a capture on the same edge
                if (abort) begin
                    state_d     = ST_IDLE;
                    tt_obs_d    = 4'b0000;
                    fail_mask_d = 4'b0000;
                    pass_d      = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    tt_obs_d = capture_obs;
                    cnt_d    = 8'd0;
                    idx_d    = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d     = ST_DONE;
                        fail_mask_d = final_mask;
                        pass_d      = (final_mask == 4'b0000);
                    end else begin
                        state_d = ST_DRIVE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are derived from the next state so they appear registered.
        busy_d = (state_d == ST_DRIVE);
        done_d = (state_d == ST_DONE);
        if (state_d == ST_DRIVE) begin
            gate_a_d = idx_d[1];
            gate_b_d = idx_d[0];
        end else begin
            gate_a_d = 1'b0;
            gate_b_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            cnt_q       <= 8'd0;
            tt_exp_q    <= 4'b0000;
            tt_obs_q    <= 4'b0000;
            fail_mask_q <= 4'b0000;
            pass_q      <= 1'b0;
            gate_a_q    <= 1'b0;
            gate_b_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            tt_exp_q    <= tt_exp_d;
            tt_obs_q    <= tt_obs_d;
            fail_mask_q <= fail_mask_d;
            pass_q      <= pass_d;
            gate_a_q    <= gate_a_d;
            gate_b_q    <= gate_b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign gate_a    = gate_a_q;
    assign gate_b    = gate_b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign tt_obs    = tt_obs_q;
    assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gate_checker.sv
// Directed, table-driven bench for gate_checker: N=2 instance with a selectable
// gate model plus an N=1 instance driving a NAND.
module tb_gate_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] tt_exp_in = 4'b0000;
    logic       gate_a, gate_b, gate_y;
    logic       busy, done, pass;
    logic [3:0] tt_obs, fail_mask;
    int         gate_mode = 0;

    logic       start1 = 1'b0;
    logic       gate_a1, gate_b1, gate_y1;
    logic       busy1, done1, pass1;
    logic [3:0] tt_obs1, fail_mask1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // gate model: 0 = NAND, 1 = tied low, 2 = tied high
    assign gate_y  = (gate_mode == 0) ? ~(gate_a & gate_b) : (gate_mode == 2);
    assign gate_y1 = ~(gate_a1 & gate_b1);

    gate_checker #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .tt_exp(tt_exp_in),
        .gate_a(gate_a), .gate_b(gate_b), .gate_y(gate_y),
        .busy(busy), .done(done), .pass(pass), .tt_obs(tt_obs), .fail_mask(fail_mask)
    );

    gate_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(1'b0), .tt_exp(4'b0111),
        .gate_a(gate_a1), .gate_b(gate_b1), .gate_y(gate_y1),
        .busy(busy1), .done(done1), .pass(pass1), .tt_obs(tt_obs1), .fail_mask(fail_mask1)
    );

    typedef struct {
        logic [3:0] texp;
        int         mode;
        logic [3:0] e_obs;
        logic [3:0] e_fm;
        logic       e_pass;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // rel = cycles since the accept edge on the N=2 instance
    task automatic check_cycle(input int rel);
        logic       e_busy;
        logic [1:0] e_vec;
        e_busy = (rel >= 1 && rel <= 8);
        e_vec  = e_busy ? 2'((rel - 1) / 2) : 2'd0;
        chk("busy", {3'b000, busy}, {3'b000, e_busy});
        chk("done", {3'b000, done}, {3'b000, (rel == 9)});
        chk("gate_ab", {2'b00, gate_a, gate_b}, {2'b00, e_vec});
    endtask

    task automatic accept(input logic [3:0] texp);
        @(negedge clk);
        start     = 1'b1;
        tt_exp_in = texp;
        @(posedge clk);
        #1;
        start     = 1'b0;
        tt_exp_in = ~texp;
    endtask

    task automatic run_check(input vec_t v);
        gate_mode = v.mode;
        accept(v.texp);
        for (int rel = 1; rel <= 10; rel++) begin
            @(negedge clk);
            check_cycle(rel);
            if (rel >= 9) begin
                chk("tt_obs", tt_obs, v.e_obs);
                chk("fail_mask", fail_mask, v.e_fm);
                chk("pass", {3'b000, pass}, {3'b000, v.e_pass});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{texp: 4'b0111, mode: 0, e_obs: 4'b0111, e_fm: 4'b0000, e_pass: 1'b1};
        vecs[1] = '{texp: 4'b1000, mode: 0, e_obs: 4'b0111, e_fm: 4'b1111, e_pass: 1'b0};
        vecs[2] = '{texp: 4'b0111, mode: 1, e_obs: 4'b0000, e_fm: 4'b0111, e_pass: 1'b0};
        vecs[3] = '{texp: 4'b0111, mode: 2, e_obs: 4'b1111, e_fm: 4'b1000, e_pass: 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {3'b000, busy}, 4'b0000);
        chk("rst_done", {3'b000, done}, 4'b0000);
        chk("rst_pass", {3'b000, pass}, 4'b0000);
        chk("rst_gate_ab", {2'b00, gate_a, gate_b}, 4'b0000);
        chk("rst_tt_obs", tt_obs, 4'b0000);
        chk("rst_fail_mask", fail_mask, 4'b0000);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_check(vecs[i]);
        end

        // start pulses during a run and in the done cycle are dropped
        gate_mode = 0;
        accept(4'b0111);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            check_cycle((c <= 10) ? c : c - 10);
            start     = (c == 3 || c == 9 || c == 10);
            tt_exp_in = 4'b0111;
        end
        start = 1'b0;
        chk("restart_pass", {3'b000, pass}, 4'b0001);

        // abort on the same edge as the second capture
        accept(4'b0111);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                check_cycle(c);
                if (c == 3) chk("partial_obs", tt_obs, 4'b0001);
            end else begin
                chk("abort_busy", {3'b000, busy}, 4'b0000);
                chk("abort_done", {3'b000, done}, 4'b0000);
                chk("abort_obs", tt_obs, 4'b0000);
                chk("abort_pass", {3'b000, pass}, 4'b0000);
                chk("abort_gate_ab", {2'b00, gate_a, gate_b}, 4'b0000);
            end
            abort = (c == 4);
        end
        abort = 1'b0;
        run_check(vecs[0]);

        // synchronous reset mid-run
        accept(4'b0111);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c <= 5) begin
                check_cycle(c);
                if (c == 5) chk("pre_rst_obs", tt_obs, 4'b0011);
            end else begin
                chk("mrst_busy", {3'b000, busy}, 4'b0000);
                chk("mrst_done", {3'b000, done}, 4'b0000);
                chk("mrst_pass", {3'b000, pass}, 4'b0000);
                chk("mrst_gate_ab", {2'b00, gate_a, gate_b}, 4'b0000);
                chk("mrst_obs", tt_obs, 4'b0000);
                chk("mrst_fm", fail_mask, 4'b0000);
            end
            rst = (c == 5);
        end
        rst = 1'b0;
        run_check(vecs[1]);

        // N=1 instance with NAND
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        for (int rel = 1; rel <= 6; rel++) begin
            @(negedge clk);
            chk("n1_busy", {3'b000, busy1}, {3'b000, (rel >= 1 && rel <= 4)});
            chk("n1_done", {3'b000, done1}, {3'b000, (rel == 5)});
            chk("n1_gate_ab", {2'b00, gate_a1, gate_b1}, (rel <= 4) ? 4'(rel - 1) : 4'b0000);
            if (rel == 5) begin
                chk("n1_obs", tt_obs1, 4'b0111);
                chk("n1_fm", fail_mask1, 4'b0000);
                chk("n1_pass", {3'b000, pass1}, 4'b0001);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
